// File: rtl/sample_frame_capture_pkg.sv
// Shared types and defaults for the triggered sample-frame capture stage.
package sample_frame_capture_pkg;

    typedef enum logic [1:0] {
        S_ARM       = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_CAPTURE   = 2'd2,
        S_PUBLISH   = 2'd3
    } cap_state_t;

    localparam int          FRAME_LEN_DEF    = 256;
    localparam int          SAMPLE_W_DEF     = 12;
    localparam int          AUTO_TIMEOUT_DEF = 4096;
    localparam logic [11:0] IDLE_CODE_DEF    = 12'd2047;

endpackage

// File: rtl/sample_frame_capture_if.sv
// Sample stream, trigger controls and published-frame bundle of the capture stage.
interface sample_frame_capture_if #(
    parameter int SAMPLE_W  = 12,
    parameter int FRAME_LEN = 256
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] trig_level;
    logic                trig_falling;
    logic                trig_auto;
    logic                hold;
    logic [3:0]          decim;
    logic [SAMPLE_W-1:0] data_display [0:FRAME_LEN-1];
    logic                frame_ready;
    logic                frame_trig;
    logic                busy;

    modport master (
        output sample_valid, sample, trig_level, trig_falling, trig_auto, hold, decim,
        input  data_display, frame_ready, frame_trig, busy
    );

    modport slave (
        input  sample_valid, sample, trig_level, trig_falling, trig_auto, hold, decim,
        output data_display, frame_ready, frame_trig, busy
    );
endinterface

// File: rtl/sample_frame_capture_trigger_detect.sv
// Edge detector: remembers the previous sample and flags a level crossing.
module trigger_detect #(
    parameter int SAMPLE_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_falling,
    input  logic                track_en,
    input  logic                arm_en,
    output logic                hit
);
    logic [SAMPLE_W-1:0] prev_r;
    logic                prev_valid_r;
    logic                edge_s;

    // Previous-sample register, refreshed on every valid sample while tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_r       <= {SAMPLE_W{1'b0}};
            prev_valid_r <= 1'b0;
        end else if (sample_valid && track_en) begin
            prev_r       <= sample;
            prev_valid_r <= 1'b1;
        end else begin
            prev_r       <= prev_r;
            prev_valid_r <= prev_valid_r;
        end
    end

    // Crossing compare; reaching the level exactly on the crossing sample counts
    always_comb begin
        edge_s = 1'b0;
        hit    = 1'b0;
        if (trig_falling) begin
            edge_s = (prev_r > trig_level) && (sample <= trig_level);
        end else begin
            edge_s = (prev_r < trig_level) && (sample >= trig_level);
        end
        if (sample_valid && arm_en && prev_valid_r) begin
            hit = edge_s;
        end else begin
            hit = 1'b0;
        end
    end
endmodule

// File: rtl/sample_frame_capture.sv
// Triggered capture: waits for an edge (or auto timeout), records a decimated
// frame, then copies it to the display buffer in a single edge so it never tears.
module sample_frame_capture
    import sample_frame_capture_pkg::*;
#(
    parameter int                  FRAME_LEN    = FRAME_LEN_DEF,
    parameter int                  SAMPLE_W     = SAMPLE_W_DEF,
    parameter int                  AUTO_TIMEOUT = AUTO_TIMEOUT_DEF,
    parameter logic [SAMPLE_W-1:0] IDLE_CODE    = IDLE_CODE_DEF
) (
    input logic                   clk,
    input logic                   rst,
    sample_frame_capture_if.slave bus
);
    localparam int               IDX_W    = $clog2(FRAME_LEN);
    localparam int               TMO_W    = $clog2(AUTO_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);

    cap_state_t          state_r;
    logic [SAMPLE_W-1:0] cap_r  [0:FRAME_LEN-1];
    logic [SAMPLE_W-1:0] disp_r [0:FRAME_LEN-1];
    logic [IDX_W-1:0]    idx_r;
    logic [3:0]          dec_r;
    logic [3:0]          dec_cnt_r;
    logic [TMO_W-1:0]    tmo_r;
    logic                auto_d_r;
    logic                trig_r;
    logic                frame_ready_r;
    logic                frame_trig_r;
    logic                hit_s;
    logic                force_s;
    logic                start_s;
    logic                wr_en_s;

    trigger_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (bus.sample_valid),
        .sample       (bus.sample),
        .trig_level   (bus.trig_level),
        .trig_falling (bus.trig_falling),
        .track_en     ((state_r == S_ARM) || (state_r == S_WAIT_TRIG)),
        .arm_en       (state_r == S_WAIT_TRIG),
        .hit          (hit_s)
    );

    // Auto-mode forced start and decimated capture write enable
    always_comb begin
        force_s = 1'b0;
        wr_en_s = 1'b0;
        if ((state_r == S_WAIT_TRIG) && bus.sample_valid && bus.trig_auto &&
            auto_d_r && (tmo_r == TMO_LAST)) begin
            force_s = 1'b1;
        end else begin
            force_s = 1'b0;
        end
        if ((state_r == S_CAPTURE) && bus.sample_valid && (dec_cnt_r == dec_r)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    assign start_s = hit_s | force_s;

    // Capture FSM with timeout, decimation and index bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= S_ARM;
            idx_r         <= IDX_W'(0);
            dec_r         <= 4'd0;
            dec_cnt_r     <= 4'd0;
            tmo_r         <= TMO_W'(0);
            auto_d_r      <= 1'b0;
            trig_r        <= 1'b0;
            frame_ready_r <= 1'b0;
            frame_trig_r  <= 1'b0;
        end else begin
            frame_ready_r <= 1'b0;
            auto_d_r      <= bus.trig_auto;
            case (state_r)
                S_ARM: begin
                    tmo_r <= TMO_W'(0);
                    if (bus.sample_valid) begin
                        state_r <= S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    if (start_s) begin
                        idx_r     <= IDX_W'(1);
                        dec_r     <= bus.decim;
                        dec_cnt_r <= 4'd0;
                        trig_r    <= hit_s;
                        tmo_r     <= TMO_W'(0);
                        state_r   <= S_CAPTURE;
                    end else if (auto_d_r != bus.trig_auto) begin
                        // a mode change restarts the timeout window
                        tmo_r <= TMO_W'(0);
                    end else if (bus.sample_valid && bus.trig_auto) begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (wr_en_s) begin
                        dec_cnt_r <= 4'd0;
                        if (idx_r == IDX_LAST) begin
                            state_r <= S_PUBLISH;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else if (bus.sample_valid) begin
                        dec_cnt_r <= dec_cnt_r + 4'd1;
                    end
                end
                S_PUBLISH: begin
                    if (!bus.hold) begin
                        frame_ready_r <= 1'b1;
                        frame_trig_r  <= trig_r;
                        state_r       <= S_ARM;
                    end
                end
                default: begin
                    state_r <= S_ARM;
                end
            endcase
        end
    end

    // Capture buffer writes and the single-edge copy into the display buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                cap_r[i]  <= IDLE_CODE;
                disp_r[i] <= IDLE_CODE;
            end
        end else begin
            if (start_s) begin
                cap_r[0] <= bus.sample;
            end else if (wr_en_s) begin
                cap_r[idx_r] <= bus.sample;
            end
            if ((state_r == S_PUBLISH) && !bus.hold) begin
                disp_r <= cap_r;
            end
        end
    end

    assign bus.data_display = disp_r;
    assign bus.frame_ready  = frame_ready_r;
    assign bus.frame_trig   = frame_trig_r;
    assign bus.busy         = (state_r != S_PUBLISH);
endmodule

// File: tb/tb_sample_frame_capture.sv
// Bench for sample_frame_capture: directed ramp table, hold/reset sequences and
// a randomized run against a sample-list reference model.
module tb_sample_frame_capture;
    localparam int FL = 256;
    localparam int AT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    sample_frame_capture_if #(.SAMPLE_W(12), .FRAME_LEN(FL)) bus ();

    sample_frame_capture #(
        .FRAME_LEN(FL), .SAMPLE_W(12), .AUTO_TIMEOUT(AT), .IDLE_CODE(12'd2047)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: valid samples since the last arm, with live controls
    logic [11:0] q_s [$];
    logic [11:0] q_l [$];
    bit          q_f [$];
    int          q_d [$];
    int          trig_i     = -1;
    int          pub_edge   = -1;
    int          mdl_frames = 0;
    bit          done       = 1'b0;
    bit          exp_trig_m = 1'b0;
    bit          mdl_on     = 1'b0;
    logic [11:0] mdl_frame [FL];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [11:0] exp_f [FL]);
        int bad;
        bad = -1;
        n_checks++;
        for (int k = 0; k < FL; k++) begin
            if ((bus.data_display[k] !== exp_f[k]) && (bad < 0)) bad = k;
        end
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: entry %0d got %0d, expected %0d",
                     name, bad, bus.data_display[bad], exp_f[bad]);
        end
    endtask

    task automatic do_reset(input bit chk);
        logic [11:0] idle_f [FL];
        bus.sample_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        if (chk) begin
            for (int k = 0; k < FL; k++) idle_f[k] = 12'd2047;
            check_frame("reset display", idle_f);
            check("reset frame_ready", bus.frame_ready, 0);
            check("reset busy", bus.busy, 1);
            check("reset frame_trig", bus.frame_trig, 0);
        end
        rst = 1'b1;
    endtask

    task automatic run_ramp(input int n, inout int j, output int rdy);
        rdy = 0;
        for (int c = 0; c < n; c++) begin
            bus.sample_valid = 1'b1;
            bus.sample = 12'(j % 4096);
            j++;
            @(negedge clk);
            if (bus.frame_ready) rdy++;
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic mdl_reset();
        q_s.delete(); q_l.delete(); q_f.delete(); q_d.delete();
        trig_i = -1; pub_edge = -1; done = 1'b0;
    endtask

    // Cycle counter plus model: trigger index, decimated picks and publish edge
    initial forever begin : mdl
        int e, i, d;
        @(posedge clk);
        cyc = cyc + 1;
        e = cyc;
        if (mdl_on && bus.sample_valid && !(done && (e <= pub_edge))) begin
            if (done) begin
                mdl_reset();
            end
            q_s.push_back(bus.sample);
            q_l.push_back(bus.trig_level);
            q_f.push_back(bus.trig_falling);
            q_d.push_back(int'(bus.decim));
            i = q_s.size() - 1;
            if ((trig_i < 0) && (i >= 1)) begin
                if (q_f[i] ? ((q_s[i-1] > q_l[i]) && (q_s[i] <= q_l[i]))
                           : ((q_s[i-1] < q_l[i]) && (q_s[i] >= q_l[i]))) begin
                    trig_i = i; exp_trig_m = 1'b1;
                end else if (bus.trig_auto && (i == AT)) begin
                    trig_i = i; exp_trig_m = 1'b0;
                end
            end
            if (trig_i >= 0) begin
                d = q_d[trig_i] + 1;
                if ((i - trig_i) == (FL - 1) * d) begin
                    for (int k = 0; k < FL; k++) mdl_frame[k] = q_s[trig_i + k * d];
                    pub_edge = e + 1;
                    done = 1'b1;
                end
            end
        end
    end

    // Model-driven output checks, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (mdl_on) begin
            check("rnd frame_ready", bus.frame_ready, int'(done && (cyc == pub_edge)));
            check("rnd busy", bus.busy, int'(!(done && (cyc == pub_edge - 1))));
            if (done && (cyc == pub_edge)) begin
                check("rnd frame_trig", bus.frame_trig, exp_trig_m);
                check_frame("rnd frame", mdl_frame);
                mdl_frames++;
            end
        end
    end

    typedef struct {
        int level; bit falling; bit auto_m; int decim; int gap; int start;
        int trig_j; bit exp_frame; bit exp_trig; int budget;
    } vec_t;

    vec_t vt [4];

    // Main stimulus sequence
    initial begin
        int j, r, got, rdy_edge, last_edge, jl;
        logic [11:0] ef [FL];
        vec_t tv;

        vt[0] = '{1000, 1'b0, 1'b0, 0, 1, 0, 1000, 1'b1, 1'b1, 3000};
        vt[1] = '{1000, 1'b1, 1'b0, 0, 1, 0, 0,    1'b0, 1'b0, 4000};
        vt[2] = '{4095, 1'b1, 1'b1, 0, 1, 0, 4096, 1'b1, 1'b0, 5000};
        vt[3] = '{100,  1'b0, 1'b0, 3, 2, 0, 100,  1'b1, 1'b1, 3000};

        bus.sample_valid = 1'b0; bus.sample = 12'd0; bus.trig_level = 12'd0;
        bus.trig_falling = 1'b0; bus.trig_auto = 1'b0; bus.hold = 1'b0; bus.decim = 4'd0;

        do_reset(1'b1);

        for (int v = 0; v < 4; v++) begin
            tv = vt[v];
            do_reset(1'b0);
            bus.trig_level = 12'(tv.level); bus.trig_falling = tv.falling;
            bus.trig_auto = tv.auto_m; bus.decim = 4'(tv.decim); bus.hold = 1'b0;
            j = 0; got = 0; rdy_edge = -1; last_edge = -1;
            jl = tv.trig_j + (FL - 1) * (tv.decim + 1);
            for (int c = 0; (c < tv.budget) && (got == 0); c++) begin
                if ((c % tv.gap) == 0) begin
                    bus.sample_valid = 1'b1;
                    bus.sample = 12'((tv.start + j) % 4096);
                    if (j == jl) last_edge = cyc + 1;
                    j++;
                end else begin
                    bus.sample_valid = 1'b0;
                end
                @(negedge clk);
                if (bus.frame_ready) begin got = 1; rdy_edge = cyc; end
            end
            bus.sample_valid = 1'b0;
            check($sformatf("vec%0d frame seen", v), got, tv.exp_frame);
            check($sformatf("vec%0d busy", v), bus.busy, 1);
            if (tv.exp_frame && (got == 1)) begin
                for (int k = 0; k < FL; k++)
                    ef[k] = 12'((tv.start + tv.trig_j + k * (tv.decim + 1)) % 4096);
                check_frame($sformatf("vec%0d frame", v), ef);
                check($sformatf("vec%0d latency", v), rdy_edge, last_edge + 1);
                check($sformatf("vec%0d frame_trig", v), bus.frame_trig, tv.exp_trig);
            end
        end

        // hold parks a finished frame until released
        do_reset(1'b0);
        bus.trig_level = 12'd1000; bus.trig_falling = 1'b0; bus.trig_auto = 1'b0;
        bus.decim = 4'd0; bus.hold = 1'b0;
        j = 0;
        run_ramp(1300, j, r);
        check("hold first frame pulses", r, 1);
        for (int k = 0; k < FL; k++) ef[k] = 12'(1000 + k);
        check_frame("hold frame A", ef);
        bus.trig_level = 12'd2000;
        run_ramp(828, j, r);
        check("hold pre-hold pulses", r, 0);
        bus.hold = 1'b1;
        run_ramp(200, j, r);
        check("hold no pulse while held", r, 0);
        check("hold busy low", bus.busy, 0);
        check_frame("hold display kept", ef);
        bus.hold = 1'b0;
        @(negedge clk);
        check("hold release frame_ready", bus.frame_ready, 1);
        for (int k = 0; k < FL; k++) ef[k] = 12'(2000 + k);
        check_frame("hold frame B", ef);
        check("hold release busy", bus.busy, 1);
        @(negedge clk);
        check("hold pulse width", bus.frame_ready, 0);

        // reset mid-capture, then flat-at-level must not trigger
        bus.trig_level = 12'd600;
        j = 0;
        run_ramp(728, j, r);
        check("rst no frame before reset", r, 0);
        do_reset(1'b1);
        bus.trig_level = 12'd500;
        for (int c = 0; c < 200; c++) begin
            bus.sample_valid = 1'b1; bus.sample = 12'd500;
            @(negedge clk);
        end
        j = 400;
        run_ramp(500, j, r);
        check("rst next frame pulses", r, 1);
        for (int k = 0; k < FL; k++) ef[k] = 12'(500 + k);
        check_frame("rst next frame", ef);
        check("rst next frame_trig", bus.frame_trig, 1);

        // randomized stream against the reference model
        do_reset(1'b0);
        bus.hold = 1'b0; bus.trig_auto = 1'b1;
        bus.trig_level = 12'($urandom_range(0, 4095));
        bus.trig_falling = 1'($urandom_range(0, 1));
        mdl_reset();
        mdl_frames = 0;
        mdl_on = 1'b1;
        for (int c = 0; (c < 30000) && (mdl_frames < 6); c++) begin
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.sample = 12'($urandom_range(0, 4095));
            bus.decim = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) bus.trig_level = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 63) == 0) bus.trig_falling = ~bus.trig_falling;
            @(negedge clk);
        end
        mdl_on = 1'b0;
        bus.sample_valid = 1'b0;
        check("rnd frames published", int'(mdl_frames >= 6), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
